// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Ports: none (package).
// Provides WORD width, fetch FSM state encoding, NOP filler and PC step.
package fetch_unit_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    FETCH_RUN    = 2'd0,
    FETCH_DRAIN  = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0: harmless filler presented to decode when nothing is valid
  localparam logic [WORD-1:0] NOP        = 32'h0000_0013;
  localparam logic [WORD-1:0] PC_STEP    = 32'd4;
  localparam logic [WORD-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding {pc, instruction} pairs between instruction memory and decode.
// Latency: a word pushed at edge N is visible on head after that edge (no bypass).
// Backpressure: none internally; the caller's credit scheme keeps pushes within DEPTH.
// Ports: clk, rst_n (sync, active-low), flush (sync clear), push/din, pop, head, count.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers words for decode.
// Latency: request at N, response at N+L, instruction valid to decode at N+L+1.
// Backpressure: requests gated by credits (outstanding + discarded + buffered < QUEUE_DEPTH).
// Ports: clk/rst_n; imem_req_* request channel; imem_resp_* response (no backpressure);
//        instr_* decode channel; redirect/redirect_pc from branch resolution;
//        halt from decode, halted once fully drained.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [WORD-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [WORD-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] instr_pc,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] CREDITS = CW'(QUEUE_DEPTH);

  fetch_state_t    state;
  logic [WORD-1:0] fetch_pc;
  logic [WORD-1:0] resp_pc;      // pc of the next response that will be kept
  logic [CW-1:0]   outstanding;  // requests whose words will be kept
  logic [CW-1:0]   discard;      // requests whose words will be dropped
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   in_use;
  logic [CW-1:0]   in_flight_nxt;

  logic run;
  logic flush;
  logic req_fire;
  logic pop;
  logic resp_drop;
  logic resp_take;
  logic push;
  logic [WORD-1:0]   target_pc;
  logic [2*WORD-1:0] q_din;
  logic [2*WORD-1:0] q_head;

  assign run         = (state == FETCH_RUN);
  assign instr_valid = run && (occupancy != '0);
  assign pop         = instr_valid && instr_ready;

  // A head leaving this cycle frees its slot before the word a new request
  // brings back can land, which is what sustains one instruction per cycle.
  assign in_use         = outstanding + discard + occupancy - CW'(pop);
  // Gated by rst_n so no request escapes while reset is held.
  assign imem_req_valid = rst_n && run && (in_use < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Older in-flight words belong to the discard pool; it drains first.
  assign resp_drop = imem_resp_valid && (discard != '0);
  assign resp_take = imem_resp_valid && (discard == '0);
  assign flush     = run && (redirect || halt);
  assign push      = run && !flush && resp_take;

  // Everything still in flight after this edge moves into the discard pool.
  assign in_flight_nxt = discard + outstanding + CW'(req_fire) - CW'(imem_resp_valid);
  assign target_pc     = redirect_pc & ALIGN_MASK;

  assign q_din = {resp_pc, imem_resp_data};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (2 * WORD)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .head  (q_head),
    .count (occupancy)
  );

  assign instr    = instr_valid ? q_head[WORD-1:0] : NOP;
  assign instr_pc = instr_valid ? q_head[2*WORD-1:WORD] : '0;
  assign halted   = (state == FETCH_HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH_RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      case (state)
        FETCH_RUN: begin
          // Redirect wins over halt: an ECALL alongside a redirect is wrong-path.
          if (redirect) begin
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= '0;
            discard     <= in_flight_nxt;
          end else if (halt) begin
            state       <= FETCH_DRAIN;
            outstanding <= '0;
            discard     <= in_flight_nxt;
          end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (push)     resp_pc  <= resp_pc + PC_STEP;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            discard     <= discard - CW'(resp_drop);
          end
        end
        FETCH_DRAIN: begin
          discard <= discard - CW'(resp_drop);
          // Leave as soon as the last stale word is being absorbed.
          if (discard == CW'(resp_drop)) state <= FETCH_HALTED;
        end
        FETCH_HALTED: begin
        end
        default: state <= FETCH_RUN;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the architectural PC, issues in-order read requests to instruction memory with a valid/ready handshake, and buffers returned words in a small queue. Presents `instr`/`instr_pc` to decode under a valid/ready handshake. Handles redirects from branch/JAL resolution by discarding stale in-flight responses, and stops fetching when decode signals ECALL completion.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset
- `QUEUE_DEPTH`, default 2, instruction buffer entries; also the cap on outstanding+buffered words (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  `WORD  word-aligned fetch address
- `imem_resp_valid`  in  1  response word valid; responses in request order, latency ≥1 cycle, no backpressure
- `imem_resp_data`  in  `WORD  fetched instruction
- `instr_valid`  out  1  head of queue valid
- `instr_ready`  in  1  decode consumes head this cycle
- `instr`  out  `WORD  instruction to decode
- `instr_pc`  out  `WORD  address of `instr`
- `redirect`  in  1  taken branch/JAL resolved; flush and refetch
- `redirect_pc`  in  `WORD  new fetch address (bit 1:0 ignored, forced 0)
- `halt`  in  1  ECALL finish from decode
- `halted`  out  1  fetch fully stopped and drained

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset → RUN.
- RUN: `imem_req_valid`=1 when `outstanding + discard + occupancy < QUEUE_DEPTH`. Request accepted (`valid & ready`) → `fetch_pc += 4`, `outstanding++`.
- Response: if `discard>0` → word dropped, `discard--`; else pushed with its PC (tracked in a parallel PC queue) and `outstanding--`. Credit rule guarantees push never hits a full queue.
- Head pops when `instr_valid & instr_ready`.
- Redirect (any state RUN): queue flushed; `fetch_pc ← redirect_pc`; `discard ← discard + outstanding − (response arriving this cycle ? 1 : 0)` adjusted so arriving word is dropped; `outstanding ← 0`. Request accepted in the redirect cycle counts as outstanding and is discarded. Head popped in the same cycle counts as consumed.
- Halt in RUN (no redirect same cycle) → DRAIN: `imem_req_valid`=0, queue flushed, all in-flight responses discarded. When `outstanding+discard`=0 → HALTED.
- Redirect and halt same cycle: redirect wins, halt ignored (ECALL is wrong-path).
- Redirect/halt in DRAIN or HALTED ignored; only reset leaves HALTED.
- `halted`=1 only in HALTED. `instr_valid`=0 in DRAIN/HALTED.
- Counters are `$clog2(QUEUE_DEPTH)+1` bits; PC arithmetic wraps modulo 2^32.

## Timing
- Reset: `imem_req_valid`=0, `instr_valid`=0, `halted`=0, `imem_req_addr`=`RESET_PC`, counters 0, queue empty. First request in first cycle with `rst_n`=1.
- Request accepted cycle N, response cycle N+L → `instr_valid`=1 at N+L+1 (registered queue, no bypass).
- Redirect cycle N → cycle N+1: `imem_req_addr`=`redirect_pc`, `imem_req_valid`=1 if credits allow, `instr_valid`=0.
- `imem_req_addr` stable while `imem_req_valid & !imem_req_ready`.
- Reset mid-operation: all state cleared next edge; responses to pre-reset requests are the memory's responsibility (memory shares `rst_n`).
- Steady state with L=1, `instr_ready`=1, QUEUE_DEPTH=2: one instruction per cycle.

## Structure
- Shared package: `WORD`, `FETCH_RUN/DRAIN/HALTED` state enum typedef, `NOP` encoding (32'h0000_0013) driven on `instr` when invalid.
- Sub-module `fetch_queue`: parameterized FIFO (data+PC, width 2×`WORD`) with synchronous `flush`, `push`, `pop`, `count`; `fetch_unit` owns FSM, PC, credit and discard counters.

## Test plan
- Reset release, memory L=1, always ready, `instr_ready`=1 → requests 0x0,0x4,0x8…; `instr_pc` 0x0 at cycle 2, then +4 every cycle.
- `instr_ready`=0 for 5 cycles, L=1 → at most 2 outstanding+buffered, `imem_req_valid` drops, no words lost; resume yields consecutive PCs.
- L=3, redirect to 0x100 with 2 requests in flight → both stale responses dropped, next `instr_pc`=0x100, no stale word ever valid.
- Redirect coincident with a response arrival and a request acceptance → both discarded, `discard` returns to 0, fetch continues from target.
- `halt` with 1 outstanding → DRAIN, `halted`=1 one cycle after last response; later `redirect` ignored; `halt`+`redirect` same cycle → redirect taken, state RUN.
- `imem_req_ready`=0 for 4 cycles → `imem_req_addr` held constant; `rst_n`=0 mid-stream → next cycle addr=`RESET_PC`, `instr_valid`=0.
